// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with write-back bypass and a counting pending-write
// scoreboard that drives the ID-stage stall directly.
module id_regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int RD_PORTS = 2,
    parameter int CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    input  logic [RD_PORTS-1:0]          rd_use,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    input  logic                         issue_en,
    input  logic                         issue_wb,
    input  logic [ADDR_W-1:0]            issue_dest,
    input  logic                         sb_clear,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_dest,
    input  logic [DATA_W-1:0]            wb_value,
    output logic                         hazard,
    output logic [(2**ADDR_W)-1:0]       busy_mask,
    output logic                         sb_err
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [CNT_W-1:0]  counts [NUM_REGS];
    logic [CNT_W-1:0]  eff    [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic issue_fire;

    // A write-back retiring this cycle already counts as resolved for hazard purposes.
    always_comb begin
        for (int a = 0; a < NUM_REGS; a++) begin
            dec[a] = wb_en && (wb_dest == ADDR_W'(a)) && (counts[a] != '0);
            eff[a] = counts[a] - CNT_W'(dec[a]);
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (rd_use[i] && (eff[rd_addr[i*ADDR_W +: ADDR_W]] != '0))
                hazard = 1'b1;
        end
        // Stall instead of letting the destination counter wrap.
        if (issue_en && issue_wb && (eff[issue_dest] == CNT_MAX))
            hazard = 1'b1;
    end

    assign issue_fire = issue_en && issue_wb && !hazard;

    always_comb begin
        for (int a = 0; a < NUM_REGS; a++) begin
            inc[a]       = issue_fire && (issue_dest == ADDR_W'(a));
            busy_mask[a] = (counts[a] != '0);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (wb_en && (wb_dest == rd_addr[i*ADDR_W +: ADDR_W]))
                rd_data[i*DATA_W +: DATA_W] = wb_value;
            else
                rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                regs[a]   <= '0;
                counts[a] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wb_en)
                regs[wb_dest] <= wb_value;
            for (int a = 0; a < NUM_REGS; a++) begin
                if (sb_clear)
                    counts[a] <= '0;
                else if (inc[a] && !dec[a])
                    counts[a] <= counts[a] + CNT_W'(1);
                else if (dec[a] && !inc[a])
                    counts[a] <= counts[a] - CNT_W'(1);
            end
            if (wb_en && (counts[wb_dest] == '0) && !sb_clear)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed vector bench for id_regfile_scoreboard (default parameters).
module tb_id_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [1:0]  rd_use;
    logic [63:0] rd_data;
    logic        issue_en, issue_wb;
    logic [3:0]  issue_dest;
    logic        sb_clear;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        hazard;
    logic [15:0] busy_mask;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    id_regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
        .issue_en(issue_en), .issue_wb(issue_wb), .issue_dest(issue_dest),
        .sb_clear(sb_clear), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .hazard(hazard), .busy_mask(busy_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          rst;
        logic [7:0]  addr;
        logic [1:0]  use_;
        bit          iss;
        logic [3:0]  idest;
        bit          clr;
        bit          wb;
        logic [3:0]  wdest;
        logic [31:0] wval;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        bit          e_haz;
        logic [15:0] e_busy;
        bit          e_err;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(bit chk, bit r, logic [7:0] addr, logic [1:0] u, bit iss,
                                logic [3:0] idest, bit clr, bit wb, logic [3:0] wdest,
                                logic [31:0] wval, logic [31:0] e0, logic [31:0] e1,
                                bit eh, logic [15:0] eb, bit ee);
        vec_t v;
        v.chk = chk; v.rst = r; v.addr = addr; v.use_ = u; v.iss = iss; v.idest = idest;
        v.clr = clr; v.wb = wb; v.wdest = wdest; v.wval = wval; v.e_rd0 = e0; v.e_rd1 = e1;
        v.e_haz = eh; v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [7:0] addr, input logic [1:0] u, input bit iss,
                         input logic [3:0] idest, input bit clr, input bit wb,
                         input logic [3:0] wdest, input logic [31:0] wval);
        rst = r; rd_addr = addr; rd_use = u; issue_en = iss; issue_wb = iss;
        issue_dest = idest; sb_clear = clr; wb_en = wb; wb_dest = wdest; wb_value = wval;
    endtask

    initial begin
        drive(1, 8'h00, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
        //                chk rst addr   use   iss idst clr wb wdst wval          rd0           rd1   haz busy      err
        vecs[0]  = mk(0, 1, 8'h00, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0000, 0);
        vecs[1]  = mk(0, 1, 8'h00, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0000, 0);
        vecs[2]  = mk(1, 0, 8'h30, 2'b11, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0000, 0);
        vecs[3]  = mk(1, 0, 8'h35, 2'b00, 0, 4'd0, 0, 1, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 16'h0000, 0);
        vecs[4]  = mk(1, 0, 8'h35, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'hDEADBEEF, 32'h0, 0, 16'h0000, 1);
        vecs[5]  = mk(1, 1, 8'h35, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'hDEADBEEF, 32'h0, 0, 16'h0000, 1);
        vecs[6]  = mk(1, 0, 8'h55, 2'b00, 1, 4'd2, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0000, 0);
        vecs[7]  = mk(1, 0, 8'h02, 2'b01, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 1, 16'h0004, 0);
        vecs[8]  = mk(1, 0, 8'h02, 2'b01, 0, 4'd0, 0, 1, 4'd2, 32'd7,        32'd7,        32'h0, 0, 16'h0004, 0);
        vecs[9]  = mk(1, 0, 8'h02, 2'b01, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'd7,        32'h0, 0, 16'h0000, 0);
        vecs[10] = mk(1, 0, 8'h00, 2'b00, 1, 4'd6, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0000, 0);
        vecs[11] = mk(1, 0, 8'h60, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0040, 0);
        vecs[12] = mk(1, 0, 8'h60, 2'b10, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 1, 16'h0040, 0);
        vecs[13] = mk(1, 0, 8'h00, 2'b00, 1, 4'd1, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0040, 0);
        vecs[14] = mk(1, 0, 8'h00, 2'b00, 1, 4'd2, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0042, 0);
        vecs[15] = mk(1, 0, 8'h00, 2'b00, 1, 4'd2, 0, 0, 4'd0, 32'h0,        32'h0,        32'h0, 0, 16'h0046, 0);
        vecs[16] = mk(1, 0, 8'h21, 2'b00, 0, 4'd0, 1, 0, 4'd0, 32'h0,        32'h0,        32'd7, 0, 16'h0046, 0);
        vecs[17] = mk(1, 0, 8'h21, 2'b00, 0, 4'd0, 0, 1, 4'd1, 32'h11,       32'h11,       32'd7, 0, 16'h0000, 0);
        vecs[18] = mk(1, 0, 8'h21, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h11,       32'd7, 0, 16'h0000, 1);
        vecs[19] = mk(1, 0, 8'h21, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0,        32'h11,       32'd7, 0, 16'h0000, 1);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].addr, vecs[k].use_, vecs[k].iss, vecs[k].idest,
                  vecs[k].clr, vecs[k].wb, vecs[k].wdest, vecs[k].wval);
            #1;
            if (vecs[k].chk) begin
                check($sformatf("v%0d rd_data0", k), rd_data[31:0], vecs[k].e_rd0);
                check($sformatf("v%0d rd_data1", k), rd_data[63:32], vecs[k].e_rd1);
                check($sformatf("v%0d hazard", k), 32'(hazard), 32'(vecs[k].e_haz));
                check($sformatf("v%0d busy_mask", k), 32'(busy_mask), 32'(vecs[k].e_busy));
                check($sformatf("v%0d sb_err", k), 32'(sb_err), 32'(vecs[k].e_err));
            end
        end

        // Saturation on r4: three issues fill the 2-bit counter, a fourth stalls.
        @(negedge clk); drive(1, 8'h00, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(0, 8'h00, 2'b00, 1, 4'd4, 0, 0, 4'd0, 32'h0);
            #1 check($sformatf("sat issue%0d hazard", k), 32'(hazard), 32'd0);
        end
        @(negedge clk); drive(0, 8'h00, 2'b00, 1, 4'd4, 0, 0, 4'd0, 32'h0);
        #1 check("sat full hazard", 32'(hazard), 32'd1);
        check("sat busy_mask", 32'(busy_mask), 32'h0010);
        // Same-cycle retire frees a slot, so the issue fires and the count holds at 3.
        @(negedge clk); drive(0, 8'h00, 2'b00, 1, 4'd4, 0, 1, 4'd4, 32'hA5);
        #1 check("sat wb hazard", 32'(hazard), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(0, 8'h00, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
            #1 check($sformatf("sat drain%0d busy", k), 32'(busy_mask), 32'h0010);
            @(negedge clk); drive(0, 8'h04, 2'b00, 0, 4'd0, 0, 1, 4'd4, 32'(k));
        end
        @(negedge clk); drive(0, 8'h04, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
        #1 check("sat drained busy", 32'(busy_mask), 32'h0000);
        check("sat drained err", 32'(sb_err), 32'd0);
        check("sat last data", rd_data[31:0], 32'd2);
        // One more retire on r4 proves the counter was exactly 3.
        @(negedge clk); drive(0, 8'h04, 2'b00, 0, 4'd0, 0, 1, 4'd4, 32'h9);
        @(negedge clk); drive(0, 8'h04, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
        #1 check("sat underflow err", 32'(sb_err), 32'd1);

        // sb_clear masks underflow on a simultaneous write-back, but the data still lands.
        @(negedge clk); drive(1, 8'h00, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
        @(negedge clk); drive(0, 8'h00, 2'b00, 0, 4'd0, 1, 1, 4'd9, 32'h1234);
        @(negedge clk); drive(0, 8'h99, 2'b00, 0, 4'd0, 0, 0, 4'd0, 32'h0);
        #1 check("clr wb err", 32'(sb_err), 32'd0);
        check("clr wb data", rd_data[63:32], 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
